event_tick_bridge: RTL and testbench

Parametrised multi-channel event bridge between full-rate input conditioners (rotary decoder, button debouncer) and slow menu/LCD logic, all on one clock. It generates a periodic clock-enable tick. Each channel gets a saturating pending-event counter, so no input pulse is lost between ticks. Pending events are delivered one per channel per tick under a ready handshake, with sticky overflow reporting.

---
 rtl/event_tick_bridge_pkg.sv | 29 ++
 rtl/event_pend_counter.sv | 71 +++++++
 rtl/event_tick_bridge.sv | 85 ++++++++
 tb/tb_event_tick_bridge.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/event_tick_bridge_pkg.sv
// ---------------------------------------------------------------------------
// event_tick_bridge_pkg
// Shared helpers for the event tick bridge.
//   clog2_w     : width of a counter that must hold values 0..val-1, minimum 1
//   pend_op_e   : the action a pending-event counter takes in a given cycle
// ---------------------------------------------------------------------------
package event_tick_bridge_pkg;

  // Width needed for a counter that counts 0..val-1. Never returns 0, so a
  // degenerate val of 1 still produces a legal one-bit vector.
  function automatic int clog2_w(input int val);
    int w;
    w = $clog2(val);
    return (w < 1) ? 1 : w;
  endfunction

  // Per-cycle decision of a pending-event counter.
  //   PEND_HOLD : no change (idle, or increment and pop cancel out)
  //   PEND_INC  : new event stored
  //   PEND_DEC  : one event delivered
  //   PEND_SAT  : new event arrived at full scale and is dropped
  typedef enum logic [1:0] {
    PEND_HOLD = 2'd0,
    PEND_INC  = 2'd1,
    PEND_DEC  = 2'd2,
    PEND_SAT  = 2'd3
  } pend_op_e;

endpackage

// File: rtl/event_pend_counter.sv
// ---------------------------------------------------------------------------
// event_pend_counter
// One channel of pending-event storage: a saturating up/down counter with a
// sticky overflow flag.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   i_inc      in   new event this cycle
//   i_pop      in   one event delivered this cycle
//   i_ovf_clr  in   clear the sticky overflow flag
//   o_cnt      out  number of pending events (registered)
//   o_overflow out  sticky: an event was dropped while at full scale
// ---------------------------------------------------------------------------
module event_pend_counter
  import event_tick_bridge_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_pop,
  input  logic             i_ovf_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_overflow
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } pend_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  pend_state_t r_state;
  pend_op_e    w_op;

  always_comb begin
    w_op = PEND_HOLD;
    unique case ({i_inc, i_pop})
      2'b10:   w_op = (r_state.cnt == CNT_MAX) ? PEND_SAT : PEND_INC;
      // A pop is only ever issued on a non-zero count; the guard keeps the
      // counter from wrapping if a caller ever violates that.
      2'b01:   w_op = (r_state.cnt != '0) ? PEND_DEC : PEND_HOLD;
      default: w_op = PEND_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
    end else begin
      unique case (w_op)
        PEND_INC: r_state.cnt <= r_state.cnt + CNT_W'(1);
        PEND_DEC: r_state.cnt <= r_state.cnt - CNT_W'(1);
        default:  r_state.cnt <= r_state.cnt;
      endcase
      // A drop in the same cycle as a clear leaves the flag set, so the
      // consumer never loses sight of a fresh overflow.
      if (w_op == PEND_SAT) begin
        r_state.ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_state.ovf <= 1'b0;
      end
    end
  end

  assign o_cnt      = r_state.cnt;
  assign o_overflow = r_state.ovf;

endmodule

// File: rtl/event_tick_bridge.sv
// ---------------------------------------------------------------------------
// event_tick_bridge
// Bridges full-rate event pulses to slow menu/LCD logic on the same clock.
// A divider produces a one-cycle tick every DIV cycles; each channel buffers
// its events in a saturating counter and hands out at most one per tick,
// gated by the consumer's ready.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   i_ev_in      in   single-cycle event pulses, one bit per channel
//   i_ev_ready   in   consumer accepts events on this tick
//   i_ovf_clr    in   per-channel sticky overflow clear
//   o_tick       out  registered one-cycle clock enable
//   o_ev_out     out  delivered event per channel, only while o_tick=1
//   o_pending_nz out  per-channel counter non-zero
//   o_overflow   out  per-channel sticky overflow
// ---------------------------------------------------------------------------
module event_tick_bridge
  import event_tick_bridge_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 4,
  parameter int DIV    = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_ev_in,
  input  logic              i_ev_ready,
  input  logic [NUM_CH-1:0] i_ovf_clr,
  output logic              o_tick,
  output logic [NUM_CH-1:0] o_ev_out,
  output logic [NUM_CH-1:0] o_pending_nz,
  output logic [NUM_CH-1:0] o_overflow
);

  localparam int               DIV_W    = clog2_w(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick;

  // The tick is registered from the terminal count, so it rises in the cycle
  // after div_cnt reaches DIV-1 and the first one lands DIV cycles after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= (r_div_cnt == DIV_LAST);
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  logic [CNT_W-1:0]  w_cnt [NUM_CH];
  logic [NUM_CH-1:0] w_nz;
  logic [NUM_CH-1:0] w_pop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_nz[g] = (w_cnt[g] != '0);
    // Delivery looks only at the registered count, so an event arriving in
    // the tick cycle is counted now and delivered on a later tick.
    assign w_pop[g] = r_tick & i_ev_ready & w_nz[g];

    event_pend_counter #(
      .CNT_W (CNT_W)
    ) u_pend (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (i_ev_in[g]),
      .i_pop      (w_pop[g]),
      .i_ovf_clr  (i_ovf_clr[g]),
      .o_cnt      (w_cnt[g]),
      .o_overflow (o_overflow[g])
    );
  end

  assign o_tick       = r_tick;
  assign o_ev_out     = w_pop;
  assign o_pending_nz = w_nz;

endmodule

// File: tb/tb_event_tick_bridge.sv
module tb_event_tick_bridge;

  logic       clk;
  logic       rst;
  logic [2:0] ev_in;
  logic       ev_ready;
  logic [2:0] ovf_clr;
  logic       tick;
  logic [2:0] ev_out;
  logic [2:0] pending_nz;
  logic [2:0] overflow;

  int total;
  int bad;
  int cyc;

  event_tick_bridge #(
    .NUM_CH (3),
    .CNT_W  (4),
    .DIV    (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_ev_in      (ev_in),
    .i_ev_ready   (ev_ready),
    .i_ovf_clr    (ovf_clr),
    .o_tick       (tick),
    .o_ev_out     (ev_out),
    .o_pending_nz (pending_nz),
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; after edge k (sampled #1 later) cyc==k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cyc=%0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to 1 time unit after rising edge n.
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      total++;
      bad++;
      $display("FAIL wait_cyc: reached=%0d required=%0d", cyc, n);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    ev_in    = '0;
    ev_ready = 1'b0;
    ovf_clr  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_ev_out", ev_out, 0);
    chk("rst_pend", pending_nz, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst      = 1'b0;
    ev_ready = 1'b1;

    // ch0: three events counted at edges 10, 20, 30
    wait_cyc(9);  ev_in = 3'b001;
    wait_cyc(10); ev_in = 3'b000;
    chk("p1_pend_after_ev", pending_nz, 3'b001);
    wait_cyc(19); ev_in = 3'b001;
    wait_cyc(20); ev_in = 3'b000;
    wait_cyc(29); ev_in = 3'b001;
    wait_cyc(30); ev_in = 3'b000;
    wait_cyc(99);
    chk("p1_tick99", tick, 0);
    chk("p1_evout99", ev_out, 0);
    wait_cyc(100);
    chk("p1_tick100", tick, 1);
    chk("p1_evout100", ev_out, 3'b001);
    wait_cyc(101);
    chk("p1_tick101", tick, 0);
    chk("p1_evout101", ev_out, 0);
    chk("p1_pend101", pending_nz, 3'b001);
    wait_cyc(200);
    chk("p1_evout200", ev_out, 3'b001);
    wait_cyc(299);
    chk("p1_pend299", pending_nz, 3'b001);
    wait_cyc(300);
    chk("p1_evout300", ev_out, 3'b001);
    wait_cyc(301);
    chk("p1_pend301", pending_nz, 0);
    chk("p1_ovf301", overflow, 0);

    // ch0: 15 events (exactly full); ch1: 20 events (5 dropped)
    wait_cyc(309); ev_in = 3'b011;
    wait_cyc(324); ev_in = 3'b010;
    wait_cyc(326); ovf_clr = 3'b010;   // same edge as a drop: set must win
    wait_cyc(327); ovf_clr = 3'b000;
    chk("p2_ovf_set_wins", overflow, 3'b010);
    wait_cyc(329); ev_in = 3'b000;
    wait_cyc(330);
    chk("p2_pend330", pending_nz, 3'b011);
    chk("p2_ovf330", overflow, 3'b010);
    wait_cyc(349); ovf_clr = 3'b010;
    wait_cyc(350); ovf_clr = 3'b000;
    chk("p2_ovf_cleared", overflow, 0);

    // Tick 400: both at 15; ch0 gets inc+pop together -> stays 15, no overflow
    wait_cyc(400);
    chk("p2_tick400", tick, 1);
    chk("p2_evout400", ev_out, 3'b011);
    ev_in = 3'b001;
    wait_cyc(401); ev_in = 3'b000;
    chk("p2_ovf_incpop_max", overflow, 0);
    chk("p2_pend401", pending_nz, 3'b011);

    // ch1 delivers on ticks 400..1800 (15 total); ch0 on 400..2000 (17 total:
    // 15 + inc at tick 400 + inc at tick 1900 when its count is 1)
    for (int k = 5; k <= 21; k++) begin
      wait_cyc(k * 100 - 1);
      chk("p2_tick_pre", tick, 0);
      wait_cyc(k * 100);
      chk("p2_tick", tick, 1);
      chk("p2_evout", ev_out, {29'd0, 1'b0, (k <= 18), (k <= 20)});
      if (k == 19) begin
        ev_in = 3'b001;
        wait_cyc(1901); ev_in = 3'b000;
        chk("p2_incpop_cnt1_pend", pending_nz, 3'b001);
      end
    end
    wait_cyc(2101);
    chk("p2_pend_drained", pending_nz, 0);
    chk("p2_ovf_end", overflow, 0);

    // ch2: one event held through two not-ready ticks
    wait_cyc(2109); ev_in = 3'b100;
    wait_cyc(2110); ev_in = 3'b000;
    ev_ready = 1'b0;
    wait_cyc(2200);
    chk("p3_tick2200", tick, 1);
    chk("p3_evout2200", ev_out, 0);
    wait_cyc(2300);
    chk("p3_evout2300", ev_out, 0);
    chk("p3_pend2300", pending_nz, 3'b100);
    wait_cyc(2350); ev_ready = 1'b1;
    wait_cyc(2400);
    chk("p3_evout2400", ev_out, 3'b100);
    wait_cyc(2401);
    chk("p3_pend2401", pending_nz, 0);

    // Reset mid-operation with pending events and an overflow
    wait_cyc(2409); ev_in = 3'b011;
    wait_cyc(2410); ev_in = 3'b000;
    wait_cyc(2419); ev_in = 3'b111;
    wait_cyc(2420); ev_in = 3'b100;
    wait_cyc(2435); ev_in = 3'b000;
    chk("p4_ovf_ch2", overflow, 3'b100);
    wait_cyc(2500);
    chk("p4_evout2500", ev_out, 3'b111);
    rst = 1'b1;
    #1;
    chk("p4_rst_tick", tick, 0);
    chk("p4_rst_evout", ev_out, 0);
    chk("p4_rst_pend", pending_nz, 0);
    chk("p4_rst_ovf", overflow, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(99);
    chk("p4_tick99", tick, 0);
    chk("p4_pend99", pending_nz, 0);
    wait_cyc(100);
    chk("p4_tick100", tick, 1);
    chk("p4_evout100", ev_out, 0);
    wait_cyc(101);
    chk("p4_tick101", tick, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
